bcd_down_counter: RTL and testbench
===================================

# bcd_down_counter

Loadable multi-digit BCD down-counter with a cascaded per-digit borrow chain, underflow pulse and zero flag. It is the decrementing counterpart to the team's up-counting decade counters. It drives countdown values in the game logic: the round timer, remaining lives and the ball-launch delay. Its packed BCD output feeds the seven-segment display path directly.

## Interface
Parameters:
- DIGITS, default 4: number of BCD digits; COUNT width is 4*DIGITS.
- RESET_VALUE, default 0: packed BCD value loaded on reset. It must contain only digits 0-9.
- SATURATE, default 1: underflow behaviour. 1 holds the count at all zeros; 0 wraps it to all nines.

Ports:
- CLK, in, 1: clock. All state changes on its rising edge.
- RESET, in, 1: synchronous, active-high reset.
- LOAD, in, 1: load strobe for LOAD_VALUE.
- LOAD_VALUE, in, 4*DIGITS: packed BCD value to load. Digit 0 is bits [3:0].
- DEC_IN, in, 1: decrement strobe. One decrement per asserted cycle.
- COUNT, out, 4*DIGITS: current packed BCD count, registered.
- ZERO, out, 1: high exactly when COUNT is all zeros, in the same cycle.
- BORROW_OUT, out, 1: registered one-cycle pulse marking an underflow.

## Operation
- Priority on each rising edge: RESET, then LOAD, then DEC_IN.
- RESET:
  - COUNT <= RESET_VALUE; BORROW_OUT <= 0.
  - ZERO follows COUNT.
  - LOAD and DEC_IN are ignored in that cycle.
- LOAD:
  - COUNT <= LOAD_VALUE, with each digit clamped independently. Digit codes A-F load as 9; digits 0-9 load unchanged.
  - A DEC_IN in the same cycle is discarded. BORROW_OUT <= 0.
- DEC_IN without LOAD or RESET:
  - Digit 0 decrements.
  - A digit at 1-9 becomes itself minus 1, and the borrow chain stops there.
  - A digit at 0 becomes 9 and passes a borrow to the next higher digit.
  - The chain is resolved combinationally within one cycle, with no ripple latency.
- Underflow: DEC_IN accepted while COUNT is all zeros.
  - BORROW_OUT <= 1 for exactly one cycle.
  - SATURATE=1: COUNT stays all zeros.
  - SATURATE=0: COUNT becomes all nines.
- All other cycles: COUNT holds; BORROW_OUT <= 0.
- COUNT always holds valid BCD. Digit codes A-F are never produced.
- No internal state exists beyond the COUNT and BORROW_OUT registers.

## Timing
- Latency: COUNT reflects a LOAD or DEC_IN on the first rising edge after the strobe is sampled.
- BORROW_OUT asserts on the same edge that COUNT applies the underflow. It deasserts on the next edge unless another underflow is accepted.
- Throughput: DEC_IN may be held high continuously, giving one decrement per cycle.
- Continuous DEC_IN at zero with SATURATE=1: BORROW_OUT stays high every cycle and COUNT stays 0.
- ZERO is decoded from the COUNT register, so it has zero additional latency relative to COUNT.
- RESET mid-countdown takes effect at the next edge. Any in-flight BORROW_OUT pulse is cleared at that edge.
- Output values after RESET: COUNT = RESET_VALUE; ZERO = (RESET_VALUE == 0); BORROW_OUT = 0.

## Test plan
- Reset: DIGITS=4, RESET_VALUE=16'h0100; assert RESET for 1 cycle -> COUNT=16'h0100, ZERO=0, BORROW_OUT=0.
- Cascaded borrow from 16'h0100:
  - DEC_IN for 1 cycle -> 16'h0099.
  - Second DEC_IN -> 16'h0098.
  - Hold DEC_IN for 98 further cycles -> 16'h0000 and ZERO=1, with BORROW_OUT low throughout.
- Underflow with SATURATE=1: LOAD 16'h0001, then DEC_IN for 2 cycles -> 16'h0000 with BORROW_OUT low, then 16'h0000 with BORROW_OUT high for exactly 1 cycle. Repeat with SATURATE=0 -> second step gives 16'h9999, ZERO=0, BORROW_OUT pulse.
- Load priority: COUNT=16'h0000 with LOAD=1, LOAD_VALUE=16'h0005 and DEC_IN=1 in the same cycle -> COUNT=16'h0005, BORROW_OUT=0.
- Clamping: LOAD 16'h0A3F -> COUNT=16'h0939; the next DEC_IN -> 16'h0938.
- Reset mid-run: hold DEC_IN from 16'h0042, then assert RESET together with DEC_IN and LOAD -> COUNT=RESET_VALUE, BORROW_OUT=0. Counting resumes on the cycle after RESET drops.

Source files
------------

// File: rtl/bcd_down_counter.sv
//==============================================================================
// Module : bcd_down_counter
// Loadable multi-digit BCD down-counter with borrow chain, underflow pulse, zero flag.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module bcd_down_counter #(
   parameter int                     DIGITS      = 4,
   parameter logic [4*DIGITS-1:0]    RESET_VALUE = '0,
   parameter bit                     SATURATE    = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  LOAD,
   input  logic [4*DIGITS-1:0]   LOAD_VALUE,
   input  logic                  DEC_IN,
   output logic [4*DIGITS-1:0]   COUNT,
   output logic                  ZERO,
   output logic                  BORROW_OUT
);

   logic [4*DIGITS-1:0] count_q;
   logic [4*DIGITS-1:0] count_d;
   logic                borrow_out_q;
   logic                borrow_out_d;

   logic [4*DIGITS-1:0] load_clamped;
   logic [4*DIGITS-1:0] count_dec;
   logic [DIGITS:0]     borrow_chain;
   logic                underflow;

   // A decrement always enters at digit 0; a borrow survives only past zero digits.
   assign borrow_chain[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] cur;
      logic [3:0] lv;

      assign cur = count_q[4*i +: 4];
      assign lv  = LOAD_VALUE[4*i +: 4];

      assign load_clamped[4*i +: 4] = (lv > 4'd9) ? 4'd9 : lv;
      assign borrow_chain[i+1]      = borrow_chain[i] & (cur == 4'd0);
      assign count_dec[4*i +: 4]    = !borrow_chain[i] ? cur :
                                      (cur == 4'd0)    ? 4'd9 : (cur - 4'd1);
   end

   // Borrow escaping the top digit means every digit was zero.
   assign underflow = borrow_chain[DIGITS];

   always_comb begin
      count_d      = count_q;
      borrow_out_d = 1'b0;
      if (LOAD) begin
         count_d = load_clamped;
      end else if (DEC_IN) begin
         count_d      = (underflow && SATURATE) ? '0 : count_dec;
         borrow_out_d = underflow;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count_q      <= RESET_VALUE;
         borrow_out_q <= 1'b0;
      end else begin
         count_q      <= count_d;
         borrow_out_q <= borrow_out_d;
      end
   end

   assign COUNT      = count_q;
   assign ZERO       = (count_q == '0);
   assign BORROW_OUT = borrow_out_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_down_counter.sv
//==============================================================================
// Module : tb_bcd_down_counter
// Scoreboard bench for bcd_down_counter, SATURATE=1 and SATURATE=0 side by side.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_bcd_down_counter;

   localparam int          DIGITS  = 4;
   localparam logic [15:0] RST_VAL = 16'h0100;
   localparam int          MAXV    = 9999;

   typedef struct packed {
      logic [15:0] count;
      logic        zero;
      logic        borrow;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        LOAD = 1'b0;
   logic [15:0] LOAD_VALUE = '0;
   logic        DEC_IN = 1'b0;

   logic [15:0] count_s, count_w;
   logic        zero_s, zero_w, borrow_s, borrow_w;

   int errors = 0;
   int checks = 0;

   exp_t q_s[$];
   exp_t q_w[$];

   int  mv_s, mv_w;
   bit  mb_s, mb_w;

   always #5 CLK = ~CLK;

   bcd_down_counter #(.DIGITS(DIGITS), .RESET_VALUE(RST_VAL), .SATURATE(1'b1)) u_sat (
      .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .LOAD_VALUE(LOAD_VALUE), .DEC_IN(DEC_IN),
      .COUNT(count_s), .ZERO(zero_s), .BORROW_OUT(borrow_s)
   );

   bcd_down_counter #(.DIGITS(DIGITS), .RESET_VALUE(RST_VAL), .SATURATE(1'b0)) u_wrap (
      .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .LOAD_VALUE(LOAD_VALUE), .DEC_IN(DEC_IN),
      .COUNT(count_w), .ZERO(zero_w), .BORROW_OUT(borrow_w)
   );

   // Reference model works on plain integers; BCD only at the boundaries.
   function automatic int bcd_to_int(input logic [15:0] v);
      int r = 0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         int dig = int'(v[4*d +: 4]);
         if (dig > 9) dig = 9;
         r = r * 10 + dig;
      end
      return r;
   endfunction

   function automatic logic [15:0] int_to_bcd(input int v);
      logic [15:0] r = '0;
      int t = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic void model_step(inout int v, inout bit b, input bit sat,
                                      input bit rst, input bit ld, input logic [15:0] lv,
                                      input bit dec);
      b = 1'b0;
      if (rst)      v = bcd_to_int(RST_VAL);
      else if (ld)  v = bcd_to_int(lv);
      else if (dec) begin
         if (v == 0) begin
            b = 1'b1;
            v = sat ? 0 : MAXV;
         end else begin
            v = v - 1;
         end
      end
   endfunction

   task automatic step(input bit rst, input bit ld, input logic [15:0] lv, input bit dec);
      exp_t e;
      @(negedge CLK);
      RESET = rst; LOAD = ld; LOAD_VALUE = lv; DEC_IN = dec;
      model_step(mv_s, mb_s, 1'b1, rst, ld, lv, dec);
      model_step(mv_w, mb_w, 1'b0, rst, ld, lv, dec);
      e.count = int_to_bcd(mv_s); e.zero = (mv_s == 0); e.borrow = mb_s;
      q_s.push_back(e);
      e.count = int_to_bcd(mv_w); e.zero = (mv_w == 0); e.borrow = mb_w;
      q_w.push_back(e);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: outputs are valid every cycle, so one expectation retires per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (q_s.size() > 0) begin
            e = q_s.pop_front();
            chk("sat_count",  count_s, e.count);
            chk("sat_zero",   {15'b0, zero_s},   {15'b0, e.zero});
            chk("sat_borrow", {15'b0, borrow_s}, {15'b0, e.borrow});
         end
         if (q_w.size() > 0) begin
            e = q_w.pop_front();
            chk("wrap_count",  count_w, e.count);
            chk("wrap_zero",   {15'b0, zero_w},   {15'b0, e.zero});
            chk("wrap_borrow", {15'b0, borrow_w}, {15'b0, e.borrow});
         end
      end
   end

   initial begin
      mv_s = 0; mv_w = 0; mb_s = 0; mb_w = 0;

      // Reset, then cascaded borrow 0100 -> 0099 -> 0098 -> ... -> 0000
      step(1, 0, 16'h0000, 0);
      step(0, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 1);
      for (int i = 0; i < 98; i++) step(0, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 0);

      // Underflow from 0001, then one idle cycle to see the pulse drop
      step(0, 1, 16'h0001, 0);
      step(0, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 0);

      // Continuous DEC_IN at zero
      step(0, 1, 16'h0000, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 16'h0000, 1);

      // Load beats decrement in the same cycle
      step(0, 1, 16'h0005, 1);

      // Clamping of A-F digit codes
      step(0, 1, 16'h0A3F, 0);
      step(0, 0, 16'h0000, 1);
      step(0, 1, 16'hFFFF, 0);
      step(0, 0, 16'h0000, 1);

      // Reset mid-run overrides LOAD and DEC_IN
      step(0, 1, 16'h0042, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 16'h0000, 1);
      step(1, 1, 16'h0777, 1);
      step(0, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 1);

      // Reset while a borrow pulse is in flight
      step(0, 1, 16'h0000, 0);
      step(0, 0, 16'h0000, 1);
      step(1, 0, 16'h0000, 1);

      // Randomised traffic, biased toward small values to hit underflow often
      for (int i = 0; i < 600; i++) begin
         logic [15:0] lv;
         bit ld, rs, dc;
         lv = 16'($urandom);
         if ($urandom_range(0, 1) == 1) lv = lv & 16'h000F;
         rs = ($urandom_range(0, 40) == 0);
         ld = ($urandom_range(0, 9) == 0);
         dc = ($urandom_range(0, 3) != 0);
         step(rs, ld, lv, dc);
      end
      step(0, 0, 16'h0000, 0);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && (q_s.size() > 0 || q_w.size() > 0); i++) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (q_s.size() != 0 || q_w.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d/%0d entries left, expected 0", q_s.size(), q_w.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
